// File: rtl/n64_mem_arbiter_pkg.sv
// Shared types and sizes for the two-port N64 memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package n64_mem_arbiter_pkg;

  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 16;
  localparam int MASK_W           = 2;
  localparam int STARVE_LIMIT_DEF = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // One port's transaction fields, in the order they are registered onto m_*.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } req_t;

endpackage

// File: rtl/n64_mem_arbiter_if.sv
// Request/ack bus used for both requester ports and the shared memory side.
// Latency: n/a (wires only).
// Backpressure: request held by the master until the slave pulses ack.
// master: drives request/write/address/wdata/wmask, receives ack/rdata.
// slave : receives request fields, drives ack/rdata.
interface n64_mem_arbiter_if;
  import n64_mem_arbiter_pkg::*;

  logic              request;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [MASK_W-1:0] wmask;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output request, write, address, wdata, wmask, input ack, rdata);
  modport slave  (input request, write, address, wdata, wmask, output ack, rdata);

endinterface

// File: rtl/n64_mem_arbiter_select.sv
// Winner selection with port-1 anti-starvation counter.
// Latency: grant decision is combinational; starve_cnt updates on the grant edge.
// Backpressure: no grant while grant_en is low; acked ports are ineligible.
// Ports: clk, reset (sync, active-low), grant_en, pN_request, pN_ack -> grant_vld, grant_port.
module n64_mem_arbiter_select
  import n64_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic grant_en,
  input  logic p0_request,
  input  logic p1_request,
  input  logic p0_ack,
  input  logic p1_ack,
  output logic grant_vld,
  output logic grant_port
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             p0_elig, p1_elig;

  always_comb begin
    p0_elig      = p0_request & ~p0_ack;
    p1_elig      = p1_request & ~p1_ack;
    grant_vld    = grant_en & (p0_elig | p1_elig);
    // Port 0 wins by default; port 1 wins when alone or once starved long enough.
    grant_port   = p1_elig & (~p0_elig | (starve_cnt_q == LIMIT_C));
    starve_cnt_d = starve_cnt_q;
    if (!p1_request) begin
      starve_cnt_d = '0;
    end else if (grant_vld && grant_port) begin
      starve_cnt_d = '0;
    end else if (grant_vld && (starve_cnt_q != LIMIT_C)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/n64_mem_arbiter.sv
// Two-port arbiter onto a single request/ack memory bus, IDLE/BUSY FSM.
// Latency: m_request rises one cycle after a request is sampled; pN_ack one cycle after m_ack.
// Backpressure: one transaction in flight; m_* held stable until m_ack.
// Ports: clk, reset (sync, active-low), p0/p1 (slave side), m (master side), busy, owner.
module n64_mem_arbiter
  import n64_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  n64_mem_arbiter_if.slave         p0,
  n64_mem_arbiter_if.slave         p1,
  n64_mem_arbiter_if.master        m,
  output logic                     busy,
  output logic                     owner
);

  state_e            state_q, state_d;
  req_t              m_fld_q, m_fld_d;
  logic              m_req_q, m_req_d;
  logic              owner_q, owner_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  req_t              p0_fld, p1_fld;
  logic              grant_en, grant_vld, grant_port;

  assign p0_fld = {p0.write, p0.address, p0.wdata, p0.wmask};
  assign p1_fld = {p1.write, p1.address, p1.wdata, p1.wmask};

  // The ack cycle is spent idle so a port still holding request while its
  // ack pulses can never be regranted, and both ports compete fairly again.
  assign grant_en = (state_q == ST_IDLE) & ~ack0_q & ~ack1_q;

  n64_mem_arbiter_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .clk        (clk),
    .reset      (reset),
    .grant_en   (grant_en),
    .p0_request (p0.request),
    .p1_request (p1.request),
    .p0_ack     (ack0_q),
    .p1_ack     (ack1_q),
    .grant_vld  (grant_vld),
    .grant_port (grant_port)
  );

  always_comb begin
    state_d  = state_q;
    m_fld_d  = m_fld_q;
    m_req_d  = m_req_q;
    owner_d  = owner_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d = ST_BUSY;
          m_req_d = 1'b1;
          owner_d = grant_port;
          m_fld_d = grant_port ? p1_fld : p0_fld;
        end
      end
      ST_BUSY: begin
        if (m.ack) begin
          state_d = ST_IDLE;
          m_req_d = 1'b0;
          if (owner_q) begin
            ack1_d   = 1'b1;
            rdata1_d = m.rdata;
          end else begin
            ack0_d   = 1'b1;
            rdata0_d = m.rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      m_fld_q  <= '0;
      m_req_q  <= 1'b0;
      owner_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      m_fld_q  <= m_fld_d;
      m_req_q  <= m_req_d;
      owner_q  <= owner_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign m.request = m_req_q;
  assign m.write   = m_fld_q.write;
  assign m.address = m_fld_q.address;
  assign m.wdata   = m_fld_q.wdata;
  assign m.wmask   = m_fld_q.wmask;
  assign p0.ack    = ack0_q;
  assign p0.rdata  = rdata0_q;
  assign p1.ack    = ack1_q;
  assign p1.rdata  = rdata1_q;
  assign busy      = (state_q == ST_BUSY);
  assign owner     = owner_q;

endmodule

// File: tb/tb_n64_mem_arbiter.sv
module tb_n64_mem_arbiter;
  import n64_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy, owner;
  always #5 clk = ~clk;

  n64_mem_arbiter_if p0_if ();
  n64_mem_arbiter_if p1_if ();
  n64_mem_arbiter_if m_if ();

  n64_mem_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .p0    (p0_if),
    .p1    (p1_if),
    .m     (m_if),
    .busy  (busy),
    .owner (owner)
  );

  typedef struct {
    logic        port;
    logic        write;
    logic [31:0] addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
  } grant_t;

  typedef struct {
    logic        port;
    logic [15:0] rdata;
  } ack_t;

  grant_t exp_grant_q[$];
  ack_t   exp_ack_q[$];
  int     total = 0;
  int     bad = 0;
  int     grant_cnt = 0;

  // Memory model: acks resp_delay cycles after m_request rises.
  logic        resp_ack = 1'b0;
  logic        spur_ack = 1'b0;
  logic [15:0] resp_rdata = 16'h0;
  int          resp_delay = 4;
  assign m_if.ack   = resp_ack | spur_ack;
  assign m_if.rdata = resp_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      resp_ack = 1'b0;
      if (m_if.request) begin
        if (cnt >= resp_delay - 1) begin
          resp_ack = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: compares every grant and every ack against the queues.
  initial begin
    logic   prev_req, prev_a0, prev_a1;
    grant_t g;
    ack_t   a;
    logic [50:0] prev_fld;
    prev_req = 1'b0;
    prev_a0  = 1'b0;
    prev_a1  = 1'b0;
    prev_fld = '0;
    forever begin
      @(negedge clk);
      if (m_if.request && !prev_req) begin
        grant_cnt++;
        if (exp_grant_q.size() == 0) begin
          chk("unexpected_grant", m_if.request, 0);
        end else begin
          g = exp_grant_q.pop_front();
          chk("grant_owner", owner, g.port);
          chk("grant_write", m_if.write, g.write);
          chk("grant_addr", m_if.address, g.addr);
          chk("grant_wdata", m_if.wdata, g.wdata);
          chk("grant_wmask", m_if.wmask, g.wmask);
          chk("grant_busy", busy, 1);
        end
      end else if (m_if.request && prev_req) begin
        chk("m_fields_stable", {m_if.write, m_if.address, m_if.wdata, m_if.wmask}, prev_fld);
      end
      if (p0_if.ack || p1_if.ack) begin
        if (exp_ack_q.size() == 0) begin
          chk("unexpected_ack", {p1_if.ack, p0_if.ack}, 0);
        end else begin
          a = exp_ack_q.pop_front();
          chk("ack_port", {p1_if.ack, p0_if.ack}, a.port ? 2'b10 : 2'b01);
          chk("ack_rdata", a.port ? p1_if.rdata : p0_if.rdata, a.rdata);
          chk("ack_m_request_low", m_if.request, 0);
        end
      end
      if (p0_if.ack) chk("p0_ack_single", prev_a0, 0);
      if (p1_if.ack) chk("p1_ack_single", prev_a1, 0);
      prev_req = m_if.request;
      prev_a0  = p0_if.ack;
      prev_a1  = p1_if.ack;
      prev_fld = {m_if.write, m_if.address, m_if.wdata, m_if.wmask};
    end
  end

  task automatic drive(input logic port, input logic req, input logic wr,
                       input logic [31:0] a, input logic [15:0] d, input logic [1:0] mk);
    if (!port) begin
      p0_if.request = req; p0_if.write = wr; p0_if.address = a; p0_if.wdata = d; p0_if.wmask = mk;
    end else begin
      p1_if.request = req; p1_if.write = wr; p1_if.address = a; p1_if.wdata = d; p1_if.wmask = mk;
    end
  endtask

  task automatic expect_txn(input logic port, input logic wr, input logic [31:0] a,
                            input logic [15:0] d, input logic [1:0] mk, input logic with_ack);
    grant_t g;
    ack_t   k;
    g.port = port; g.write = wr; g.addr = a; g.wdata = d; g.wmask = mk;
    exp_grant_q.push_back(g);
    if (with_ack) begin
      k.port = port; k.rdata = resp_rdata;
      exp_ack_q.push_back(k);
    end
  endtask

  task automatic wait_acks(input string name, input int max_cyc);
    int n;
    n = 0;
    while (exp_ack_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_ack_q.size() == 0, 1);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_m"}, {m_if.request, m_if.write, m_if.address, m_if.wdata, m_if.wmask}, 0);
    chk({name, "_p"}, {p0_if.ack, p1_if.ack, p0_if.rdata, p1_if.rdata}, 0);
    chk({name, "_st"}, {busy, owner}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    repeat (2) @(negedge clk);
    check_reset_vals("reset_state");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // p0 write, memory acks after 4 cycles.
    resp_delay = 4;
    resp_rdata = 16'hA5A5;
    expect_txn(1'b0, 1'b1, 32'h0000_1000, 16'hBEEF, 2'b11, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_1000, 16'hBEEF, 2'b11);
    @(negedge clk);
    chk("grant_latency", {m_if.request, busy}, 2'b11);
    wait_acks("p0_write_done", 20);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    repeat (3) @(negedge clk);

    // p1 read with data returned.
    resp_rdata = 16'h1234;
    expect_txn(1'b1, 1'b0, 32'h0200_0000, 16'h0000, 2'b00, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 32'h0200_0000, 16'h0000, 2'b00);
    wait_acks("p1_read_done", 20);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    chk("owner_p1", owner, 1);
    repeat (3) @(negedge clk);

    // Both ports request continuously: 0,0,0,1,0,0,0,1.
    resp_delay = 2;
    resp_rdata = 16'h0F0F;
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 3) expect_txn(1'b1, 1'b0, 32'h0000_2200, 16'h0000, 2'b01, 1'b1);
      else            expect_txn(1'b0, 1'b1, 32'h0000_1100, 16'hCAFE, 2'b10, 1'b1);
    end
    n = grant_cnt + 8;
    drive(1'b0, 1'b1, 1'b1, 32'h0000_1100, 16'hCAFE, 2'b10);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_2200, 16'h0000, 2'b01);
    for (int c = 0; c < 300 && grant_cnt < n; c++) @(negedge clk);
    chk("starve_grants_seen", grant_cnt >= n, 1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    wait_acks("starve_done", 20);
    repeat (4) @(negedge clk);
    chk("starve_no_extra_grant", exp_grant_q.size(), 0);

    // p0 drops request mid-transaction: still completes once.
    resp_delay = 5;
    resp_rdata = 16'h7E57;
    expect_txn(1'b0, 1'b0, 32'h0000_0040, 16'h0000, 2'b11, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 32'h0000_0040, 16'h0000, 2'b11);
    @(negedge clk);
    chk("abort_busy", busy, 1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    wait_acks("drop_req_done", 20);
    repeat (4) @(negedge clk);
    chk("drop_req_idle", {busy, m_if.request}, 0);

    // Reset two cycles into BUSY: transaction abandoned, no ack.
    resp_delay = 20;
    expect_txn(1'b0, 1'b1, 32'h0000_0080, 16'h5555, 2'b01, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0080, 16'h5555, 2'b01);
    @(negedge clk);
    chk("rst_busy_1", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    @(negedge clk);
    check_reset_vals("reset_in_busy");
    reset = 1'b1;
    repeat (25) @(negedge clk);
    chk("reset_stays_idle", {busy, m_if.request}, 0);

    // Spurious m_ack in IDLE.
    resp_delay = 3;
    resp_rdata = 16'hFFFF;
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    @(negedge clk);
    chk("spurious_no_ack", {p0_if.ack, p1_if.ack}, 0);
    chk("spurious_idle", {busy, m_if.request}, 0);

    // Normal operation after the spurious ack.
    resp_rdata = 16'h4321;
    expect_txn(1'b1, 1'b1, 32'h0000_3000, 16'h9999, 2'b10, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 32'h0000_3000, 16'h9999, 2'b10);
    @(negedge clk);
    chk("post_spur_grant", {m_if.request, owner}, 2'b11);
    wait_acks("post_spur_done", 20);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00);
    repeat (3) @(negedge clk);
    chk("grant_queue_drained", exp_grant_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
